fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction decoder.
- Owns the PC and issues requests to instruction memory over a req/ack handshake.
- Latches the returned word into an instruction register and presents it to decode through a valid/ready handshake, with the op/funct fields pre-split.
- Accepts branch redirects from execute; flushes held or in-flight instructions.

Parameters:
- PC_W, 8, PC / instruction address width in bits.
- INST_W, 16, instruction width; op = inst[INST_W-1:INST_W-5], funct = inst[0].
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request; held until imem_ack.
- imem_addr  out  PC_W  fetch address; stable while imem_req=1.
- imem_ack  in  1  one-cycle pulse; imem_rdata valid in the same cycle.
- imem_rdata  in  INST_W  fetched word.
- inst_valid  out  1  instruction register holds a valid instruction.
- inst_ready  in  1  decode/execute consumes the instruction this cycle.
- inst  out  INST_W  instruction register.
- op  out  5  inst[INST_W-1:INST_W-5], combinational from inst.
- funct  out  1  inst[0], combinational from inst.
- inst_pc  out  PC_W  address of inst.
- pc_plus1  out  PC_W  inst_pc+1 mod 2^PC_W, used as the JAL link value.
- redirect  in  1  taken branch/jump; flush and refetch.
- redirect_pc  in  PC_W  new fetch address, sampled when redirect=1.
- halt  in  1  level; blocks starting new fetches.

Behaviour:
- Reset values (asynchronous):
  - Outputs: imem_req=0, imem_addr=0, inst_valid=0, inst=0, inst_pc=0.
  - Internal: pc=RESET_PC, state=IDLE.
  - Any outstanding memory request is abandoned; imem must tolerate this.
- State machine (registered outputs; imem_addr comes from a dedicated addr_q register, not from pc):
  - IDLE, imem_req=0:
    - redirect: pc<=redirect_pc.
    - !halt: addr_q<=pc (or redirect_pc if redirect) and go to REQ.
  - REQ, imem_req=1:
    - ack && !redirect: inst<=imem_rdata, inst_pc<=addr_q, pc<=addr_q+1, inst_valid<=1, go to FULL.
    - ack && redirect: drop rdata, pc<=redirect_pc, go to IDLE.
    - !ack && redirect: pc<=redirect_pc, go to DROP.
  - FULL, inst_valid=1, imem_req=0:
    - redirect (takes priority over inst_ready): inst_valid<=0, pc<=redirect_pc, go to IDLE.
    - else inst_ready: inst_valid<=0; if halt go to IDLE, else addr_q<=pc and go to REQ.
    - else hold; inst and inst_pc remain stable.
  - DROP, imem_req=1, addr_q unchanged:
    - redirect: pc<=redirect_pc, stay in DROP (last redirect wins).
    - ack: discard rdata; go to IDLE if halt, else REQ with addr_q<=pc (or redirect_pc if redirect in the same cycle).
- Latency and throughput:
  - With single-cycle memory (ack in the cycle after req rises), inst_valid rises 2 cycles after leaving IDLE.
  - Throughput is one instruction per 2 cycles when inst_ready is held high.
- Arithmetic: pc and pc_plus1 wrap modulo 2^PC_W (0xFF+1 = 0x00 for PC_W=8).
- Halt: never retracts an asserted imem_req; only gates entry into REQ.
- Invariant: imem_req and inst_valid are never both 1.

Decomposition:
- Shared package cpu_pkg holds:
  - INST_W, OP_W=5, op field positions, funct bit position.
  - fetch state enum {IDLE, REQ, FULL, DROP}.
- The decoder already consumes the same op field constants.
- Single module, no natural sub-module.

Test Plan:
- Reset release, imem acks every request after 1 cycle with rdata=addr+0x1000, inst_ready=1 -> inst_pc sequence 0,1,2,3; inst=0x1000,0x1001,…; inst_valid high every other cycle; imem_addr stable while req=1.
- Backpressure: inst_ready=0 for 5 cycles with inst=0xA801 -> inst_valid stays 1, op=0x15, funct=1, imem_req=0 throughout; fetch of pc+1 starts the cycle after inst_ready=1.
- Redirect in FULL with inst_ready=1 and redirect_pc=0x40 -> instruction dropped, no consume effect, next imem_addr=0x40.
- Redirect in REQ with ack delayed 3 cycles, redirect_pc=0x20 -> state DROP, imem_req held at old addr until ack, rdata discarded (inst_valid stays 0), then imem_addr=0x20.
- Wrap: RESET_PC=0xFF -> inst_pc=0xFF, pc_plus1=0x00, next imem_addr=0x00.
- halt=1 in FULL at consume -> IDLE, imem_req=0 indefinitely; halt=0 -> request at the next pc; asynchronous reset asserted mid-REQ -> imem_req=0 immediately, pc=RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout and the fetch-stage state
// encoding. The decoder slices op/funct with the same constants.
package cpu_pkg;

  localparam int INST_W    = 16;
  localparam int OP_W      = 5;
  localparam int OP_MSB    = INST_W - 1;
  localparam int OP_LSB    = INST_W - OP_W;
  localparam int FUNCT_BIT = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FULL = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches from instruction memory over a
// req/ack handshake, holds one instruction for decode and flushes on redirect.
//
// Handshakes:
//   imem: imem_req is held high with a stable imem_addr until imem_ack pulses;
//         imem_rdata is valid in the ack cycle. A request is never withdrawn
//         except by reset.
//   decode: inst/inst_pc are stable while inst_valid=1; the instruction is
//         consumed on a rising edge where inst_valid && inst_ready, unless
//         redirect is high in that cycle (redirect wins and flushes it).
// imem_req and inst_valid are decoded from the state register, so they can
// never be high together.
module fetch_unit
  import cpu_pkg::fetch_state_e;
  import cpu_pkg::IDLE;
  import cpu_pkg::REQ;
  import cpu_pkg::FULL;
  import cpu_pkg::DROP;
  import cpu_pkg::OP_W;
  import cpu_pkg::FUNCT_BIT;
#(
  parameter int               PC_W     = 8,
  parameter int               INST_W   = cpu_pkg::INST_W,
  parameter logic [PC_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [OP_W-1:0]   op,
  output logic              funct,
  output logic [PC_W-1:0]   inst_pc,
  output logic [PC_W-1:0]   pc_plus1,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              halt,
  output fetch_state_e      state_dbg
);

  fetch_state_e      state, state_n;
  logic [PC_W-1:0]   pc, pc_n;
  logic [PC_W-1:0]   addr_q, addr_n;
  logic [INST_W-1:0] inst_q, inst_n;
  logic [PC_W-1:0]   inst_pc_q, inst_pc_n;

  // State and datapath registers; reset abandons any outstanding request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      addr_q    <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      addr_q    <= addr_n;
      inst_q    <= inst_n;
      inst_pc_q <= inst_pc_n;
    end
  end

  // Next-state and next-datapath decode for the fetch sequencer.
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    addr_n    = addr_q;
    inst_n    = inst_q;
    inst_pc_n = inst_pc_q;
    case (state)
      IDLE: begin
        if (redirect) pc_n = redirect_pc;
        if (!halt) begin
          addr_n  = redirect ? redirect_pc : pc;
          state_n = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          // Either drop the word arriving now, or wait out the in-flight
          // access in DROP; the target is refetched afterwards.
          pc_n    = redirect_pc;
          state_n = imem_ack ? IDLE : DROP;
        end else if (imem_ack) begin
          inst_n    = imem_rdata;
          inst_pc_n = addr_q;
          pc_n      = addr_q + PC_W'(1);
          state_n   = FULL;
        end
      end
      FULL: begin
        if (redirect) begin
          pc_n    = redirect_pc;
          state_n = IDLE;
        end else if (inst_ready) begin
          if (halt) begin
            state_n = IDLE;
          end else begin
            addr_n  = pc;
            state_n = REQ;
          end
        end
      end
      DROP: begin
        // addr_q stays put so the abandoned access completes as issued.
        if (redirect) pc_n = redirect_pc;
        if (imem_ack) begin
          if (halt) begin
            state_n = IDLE;
          end else begin
            addr_n  = redirect ? redirect_pc : pc;
            state_n = REQ;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign imem_req   = (state == REQ) || (state == DROP);
  assign imem_addr  = addr_q;
  assign inst_valid = (state == FULL);
  assign inst       = inst_q;
  assign op         = inst_q[INST_W-1 -: OP_W];
  assign funct      = inst_q[FUNCT_BIT];
  assign inst_pc    = inst_pc_q;
  assign pc_plus1   = inst_pc_q + PC_W'(1);
  assign state_dbg  = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a reactive memory model, a scoreboard of
// expected {inst_pc, inst} pairs popped on each consume, directed scenarios,
// and a second instance built with RESET_PC=0xFF for PC wrap-around.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [15:0] inst;
  logic [4:0]  op;
  logic        funct;
  logic [7:0]  inst_pc;
  logic [7:0]  pc_plus1;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic        halt = 1'b1;
  fetch_state_e state_dbg;

  logic        w_req;
  logic [7:0]  w_addr;
  logic        w_ack = 1'b0;
  logic [15:0] w_rdata = '0;
  logic        w_valid;
  logic [15:0] w_inst;
  logic [4:0]  w_op;
  logic        w_funct;
  logic [7:0]  w_inst_pc;
  logic [7:0]  w_pc_plus1;
  fetch_state_e w_state;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          mem_delay = 0;
  int          wait_cnt = 0;
  logic [7:0]  held_addr = '0;
  logic        use_ovr = 1'b0;
  logic [15:0] ovr_word = 16'hA801;
  logic [23:0] exp_q[$];

  fetch_unit #(.PC_W(8), .INST_W(16), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .op(op), .funct(funct),
    .inst_pc(inst_pc), .pc_plus1(pc_plus1), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt), .state_dbg(state_dbg)
  );

  fetch_unit #(.PC_W(8), .INST_W(16), .RESET_PC(8'hFF)) dut_wrap (
    .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata), .inst_valid(w_valid),
    .inst_ready(1'b1), .inst(w_inst), .op(w_op), .funct(w_funct),
    .inst_pc(w_inst_pc), .pc_plus1(w_pc_plus1), .redirect(1'b0),
    .redirect_pc(8'h00), .halt(1'b0), .state_dbg(w_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!inst_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_seen"}, 32'(inst_valid), 32'd1);
  endtask

  // Memory model for the main instance: acks after mem_delay extra cycles,
  // checks address stability and the req/valid exclusion.
  always @(negedge clk) begin
    check("req_valid_excl", 32'(imem_req & inst_valid), 32'd0);
    if (imem_req && !reset) begin
      if (wait_cnt == 0) held_addr = imem_addr;
      else check("addr_stable", 32'(imem_addr), 32'(held_addr));
      if (wait_cnt == mem_delay) begin
        imem_ack   = 1'b1;
        imem_rdata = use_ovr ? ovr_word : 16'h1000 + {8'h00, imem_addr};
        wait_cnt   = 0;
      end else begin
        imem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      imem_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  // Single-cycle memory for the wrap instance.
  always @(negedge clk) begin
    w_ack   = w_req;
    w_rdata = 16'h1000 + {8'h00, w_addr};
  end

  // Scoreboard: every consumed instruction must match the next expectation.
  always @(posedge clk) begin : sb_mon
    logic [23:0] e;
    if (!reset && inst_valid && inst_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", {8'h00, inst_pc, inst}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("sb_inst", 32'({inst_pc, inst}), 32'(e));
        check("sb_op", 32'(op), 32'(e[15:11]));
        check("sb_funct", 32'(funct), 32'(e[0]));
        check("sb_pc_plus1", 32'(pc_plus1), 32'(8'(e[23:16] + 8'd1)));
      end
    end
  end

  // Wrap-around instance: first fetch at 0xFF, next at 0x00.
  initial begin : wrap_chk
    int n;
    wait (reset == 1'b0);
    n = 0;
    @(negedge clk);
    while (!w_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wrap_valid", 32'(w_valid), 32'd1);
    check("wrap_inst_pc", 32'(w_inst_pc), 32'hFF);
    check("wrap_pc_plus1", 32'(w_pc_plus1), 32'h00);
    check("wrap_inst", 32'(w_inst), 32'h10FF);
    @(negedge clk);
    check("wrap_req", 32'(w_req), 32'd1);
    check("wrap_next_addr", 32'(w_addr), 32'h00);
  end

  // Directed scenarios.
  initial begin : main_seq
    int prev;
    repeat (2) @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", 32'(inst), 32'd0);
    check("rst_inst_pc", 32'(inst_pc), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));

    // Streaming with ready held high.
    for (int i = 0; i < 4; i++) exp_q.push_back({8'(i), 16'h1000 + 16'(i)});
    halt  = 1'b0;
    reset = 1'b0;
    prev  = 0;
    for (int k = 0; k < 4; k++) begin
      wait_valid("s1_valid");
      if (k > 0) check("s1_period", 32'(cyc - prev), 32'd2);
      prev = cyc;
      if (k == 3) halt = 1'b1;
    end
    repeat (3) begin
      @(negedge clk);
      check("s1_halt_req", 32'(imem_req), 32'd0);
    end
    check("s1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure on a held instruction.
    use_ovr = 1'b1;
    exp_q.push_back({8'h04, 16'hA801});
    inst_ready = 1'b0;
    halt       = 1'b0;
    wait_valid("s2_valid");
    use_ovr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("s2_hold_valid", 32'(inst_valid), 32'd1);
      check("s2_op", 32'(op), 32'h15);
      check("s2_funct", 32'(funct), 32'd1);
      check("s2_req", 32'(imem_req), 32'd0);
      check("s2_inst_pc", 32'(inst_pc), 32'h04);
    end
    inst_ready = 1'b1;
    @(negedge clk);
    check("s2_next_req", 32'(imem_req), 32'd1);
    check("s2_next_addr", 32'(imem_addr), 32'h05);

    // Redirect while FULL with ready high: the held instruction is flushed.
    @(negedge clk);
    check("s3_valid", 32'(inst_valid), 32'd1);
    check("s3_held", 32'({inst_pc, inst}), 32'h051005);
    redirect    = 1'b1;
    redirect_pc = 8'h40;
    @(negedge clk);
    redirect = 1'b0;
    check("s3_state", 32'(state_dbg), 32'(IDLE));
    check("s3_flushed", 32'(inst_valid), 32'd0);
    exp_q.push_back({8'h40, 16'h1040});
    @(negedge clk);
    check("s3_req", 32'(imem_req), 32'd1);
    check("s3_addr", 32'(imem_addr), 32'h40);
    halt = 1'b1;
    wait_valid("s3_fetch");
    @(negedge clk);
    check("s3_idle", 32'(state_dbg), 32'(IDLE));
    check("s3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Redirect during a slow fetch: wait it out in DROP, then refetch.
    mem_delay = 3;
    halt      = 1'b0;
    @(negedge clk);
    check("s4_state_req", 32'(state_dbg), 32'(REQ));
    check("s4_addr", 32'(imem_addr), 32'h41);
    redirect    = 1'b1;
    redirect_pc = 8'h20;
    @(negedge clk);
    redirect = 1'b0;
    check("s4_state_drop", 32'(state_dbg), 32'(DROP));
    check("s4_drop_req", 32'(imem_req), 32'd1);
    check("s4_drop_addr", 32'(imem_addr), 32'h41);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_addr != 8'h41) break;
      check("s4_drop_valid", 32'(inst_valid), 32'd0);
    end
    check("s4_new_addr", 32'(imem_addr), 32'h20);
    check("s4_new_state", 32'(state_dbg), 32'(REQ));
    check("s4_rdata_dropped", 32'(inst), 32'h1040);
    exp_q.push_back({8'h20, 16'h1020});
    halt = 1'b1;
    wait_valid("s4_fetch");

    // Halt holds the unit idle; release resumes at the next PC.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("s6_halt_req", 32'(imem_req), 32'd0);
      check("s6_halt_state", 32'(state_dbg), 32'(IDLE));
    end
    halt = 1'b0;
    @(negedge clk);
    check("s6_resume_req", 32'(imem_req), 32'd1);
    check("s6_resume_addr", 32'(imem_addr), 32'h21);

    // Asynchronous reset in the middle of a request.
    reset = 1'b1;
    #1;
    check("s6_arst_req", 32'(imem_req), 32'd0);
    check("s6_arst_state", 32'(state_dbg), 32'(IDLE));
    check("s6_arst_addr", 32'(imem_addr), 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    mem_delay = 0;
    exp_q.push_back({8'h00, 16'h1000});
    @(negedge clk);
    check("s6_post_rst_req", 32'(imem_req), 32'd1);
    check("s6_post_rst_addr", 32'(imem_addr), 32'h00);
    halt = 1'b1;
    wait_valid("s6_fetch");
    repeat (2) @(negedge clk);
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
